clock24_ctrl: RTL and testbench

Run/set controller for the 24-hour BCD clock counter. It generates the minute-advance enable that drives the counter in normal running. A two-button set sequence captures the displayed time, lets the user edit hours then minutes, and returns the edited time through a one-cycle parallel load. It sits between the push-button front end (inputs already synchronised) and the `clock24` counter datapath.

---
 rtl/clock24_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_clock24_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock24_ctrl.sv
// clock24_ctrl -- run/set controller for the 24-hour BCD clock counter.
//
// In RUN it divides clk down to a one-cycle minute-advance enable (cnt_en).
// A mode press captures the counter time into edit registers, the inc
// button then edits hours (SET_HOUR) and minutes (SET_MIN), and a final
// mode press returns the edited time through a one-cycle load strobe.
//
// Ports:
//   clk                      single clock, rising edge
//   reset                    asynchronous, active-low
//   btn_mode, btn_inc        synchronised button levels
//   min1/min10/hour1/hour10  current counter time, BCD (in)
//   cnt_en                   one-cycle minute-advance enable (out)
//   load                     one-cycle parallel-load strobe (out)
//   ld_min1..ld_hour10       edit registers, BCD (out)
//   mode                     00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 LOAD
//
// Build option: define CLOCK24_CTRL_AUTOREP_EN to enable auto-repeat of
// btn_inc (REP_DLY cycles until the first repeat, then every REP_PER).
module clock24_ctrl #(
   parameter int unsigned TICK_DIV = 60,
   parameter int unsigned REP_DLY  = 8,
   parameter int unsigned REP_PER  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] min1,
   input  logic [2:0] min10,
   input  logic [3:0] hour1,
   input  logic [1:0] hour10,
   output logic       cnt_en,
   output logic       load,
   output logic [3:0] ld_min1,
   output logic [2:0] ld_min10,
   output logic [3:0] ld_hour1,
   output logic [1:0] ld_hour10,
   output logic [1:0] mode
);

   localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_RUN      = 2'b00,
      S_SET_HOUR = 2'b01,
      S_SET_MIN  = 2'b10,
      S_LOAD     = 2'b11
   } state_t;

   state_t        state, state_nx;
   logic [PW-1:0] presc;
   logic          mode_q, inc_q;
   logic          mode_press, inc_press, inc_step;
   logic          capture, step_hour, step_min;
   logic [3:0]    e_min1, e_hour1, m_nx1, h_nx1;
   logic [2:0]    e_min10, m_nx10;
   logic [1:0]    e_hour10, h_nx10;

   // Elaboration-time sanity check of the timing parameters.
   if (TICK_DIV < 2 || REP_PER == 0 || REP_PER > REP_DLY) begin : g_param_check
      $error("clock24_ctrl: TICK_DIV must be >= 2 and 0 < REP_PER <= REP_DLY");
   end

   // Previous-sample registers reset to 1 so a button held through reset
   // does not register as a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q <= 1'b1;
         inc_q  <= 1'b1;
      end else begin
         mode_q <= btn_mode;
         inc_q  <= btn_inc;
      end
   end

   assign mode_press = btn_mode & ~mode_q;
   assign inc_press  = btn_inc  & ~inc_q;

`ifdef CLOCK24_CTRL_AUTOREP_EN
   localparam int unsigned RW = $clog2(REP_DLY + 1);

   logic [RW-1:0] rep_cnt;
   logic          rep_held, rep_fire;

   // rep_cnt counts held cycles after the initial press. Reloading it with
   // REP_DLY-REP_PER after a repeat makes later repeats REP_PER apart.
   // A mode press (state change) counts as "not held" and clears it.
   assign rep_held = btn_inc & inc_q & ~mode_press &
                     ((state == S_SET_HOUR) | (state == S_SET_MIN));
   assign rep_fire = rep_held & (rep_cnt == RW'(REP_DLY - 1));
   assign inc_step = inc_press | rep_fire;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rep_cnt <= '0;
      else if (!rep_held)
         rep_cnt <= '0;
      else if (rep_fire)
         rep_cnt <= RW'(REP_DLY - REP_PER);
      else
         rep_cnt <= rep_cnt + RW'(1);
   end
`else
   assign inc_step = inc_press;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= S_RUN;
      else
         state <= state_nx;
   end

   // Mode press takes priority over any increment in the same cycle.
   always_comb begin
      state_nx  = state;
      cnt_en    = 1'b0;
      load      = 1'b0;
      capture   = 1'b0;
      step_hour = 1'b0;
      step_min  = 1'b0;
      case (state)
         S_RUN: begin
            cnt_en = (presc == PRESC_MAX);
            if (mode_press) begin
               capture  = 1'b1;
               state_nx = S_SET_HOUR;
            end
         end
         S_SET_HOUR: begin
            if (mode_press)
               state_nx = S_SET_MIN;
            else if (inc_step)
               step_hour = 1'b1;
         end
         S_SET_MIN: begin
            if (mode_press)
               state_nx = S_LOAD;
            else if (inc_step)
               step_min = 1'b1;
         end
         S_LOAD: begin
            load     = 1'b1;
            state_nx = S_RUN;
         end
         default: state_nx = S_RUN;
      endcase
   end

   // Prescaler runs only while staying in RUN, so every RUN entry starts
   // from 0 and the first cnt_en comes TICK_DIV cycles later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         presc <= '0;
      else if (state == S_RUN && state_nx == S_RUN)
         presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
      else
         presc <= '0;
   end

   // BCD increments: hours wrap 23->00, minutes wrap 59->00, no carry.
   always_comb begin
      h_nx1  = e_hour1 + 4'd1;
      h_nx10 = e_hour10;
      if (e_hour10 == 2'd2 && e_hour1 == 4'd3) begin
         h_nx1  = '0;
         h_nx10 = '0;
      end else if (e_hour1 == 4'd9) begin
         h_nx1  = '0;
         h_nx10 = e_hour10 + 2'd1;
      end
      m_nx1  = e_min1 + 4'd1;
      m_nx10 = e_min10;
      if (e_min1 == 4'd9) begin
         m_nx1  = '0;
         m_nx10 = (e_min10 == 3'd5) ? '0 : e_min10 + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_min1   <= '0;
         e_min10  <= '0;
         e_hour1  <= '0;
         e_hour10 <= '0;
      end else if (capture) begin
         e_min1   <= min1;
         e_min10  <= min10;
         e_hour1  <= hour1;
         e_hour10 <= hour10;
      end else if (step_hour) begin
         e_hour1  <= h_nx1;
         e_hour10 <= h_nx10;
      end else if (step_min) begin
         e_min1   <= m_nx1;
         e_min10  <= m_nx10;
      end
   end

   assign ld_min1   = e_min1;
   assign ld_min10  = e_min10;
   assign ld_hour1  = e_hour1;
   assign ld_hour10 = e_hour10;
   assign mode      = state;

endmodule

// File: tb/tb_clock24_ctrl.sv
// Scoreboard bench for clock24_ctrl: stimulus tasks push expected output
// events (state/edit-register changes, cnt_en pulses, load pulses) with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_clock24_ctrl;

   localparam int unsigned TD = 4;
   localparam int unsigned RD = 8;
   localparam int unsigned RP = 4;

   localparam logic [1:0] K_CHG = 2'd0;
   localparam logic [1:0] K_CNT = 2'd1;
   localparam logic [1:0] K_LD  = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      int         stamp;
      logic [1:0] mode;
      logic [3:0] m1;
      logic [2:0] m10;
      logic [3:0] h1;
      logic [1:0] h10;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [3:0] min1, hour1;
   logic [2:0] min10;
   logic [1:0] hour10;
   logic       cnt_en, load;
   logic [3:0] ld_min1, ld_hour1;
   logic [2:0] ld_min10;
   logic [1:0] ld_hour10;
   logic [1:0] mode;

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t expq[$];

   // Reference model of the controller's visible state.
   int  e_mode = 0;
   int  e_hour = 0;
   int  e_min = 0;
   int  cur_hour = 0;
   int  cur_min = 0;
   int  run_start = 0;

   clock24_ctrl #(.TICK_DIV(TD), .REP_DLY(RD), .REP_PER(RP)) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .min1(min1), .min10(min10), .hour1(hour1), .hour10(hour10),
      .cnt_en(cnt_en), .load(load),
      .ld_min1(ld_min1), .ld_min10(ld_min10), .ld_hour1(ld_hour1), .ld_hour10(ld_hour10),
      .mode(mode)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push(input logic [1:0] kind, input int stamp);
      ev_t e;
      e.kind  = kind;
      e.stamp = stamp;
      e.mode  = 2'(e_mode);
      e.m1    = 4'(e_min % 10);
      e.m10   = 3'(e_min / 10);
      e.h1    = 4'(e_hour % 10);
      e.h10   = 2'(e_hour / 10);
      expq.push_back(e);
   endfunction

   task automatic check_ev(input ev_t act, input string name);
      ev_t ex;
      checks++;
      if (expq.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected event at cycle %0d (mode=%b ld=%0d%0d:%0d%0d), none required",
                  name, act.stamp, act.mode, act.h10, act.h1, act.m10, act.m1);
      end else begin
         ex = expq.pop_front();
         if (act != ex) begin
            errors++;
            $display("FAIL %s: got kind=%0d cyc=%0d mode=%b ld=%0d%0d:%0d%0d, required kind=%0d cyc=%0d mode=%b ld=%0d%0d:%0d%0d",
                     name, act.kind, act.stamp, act.mode, act.h10, act.h1, act.m10, act.m1,
                     ex.kind, ex.stamp, ex.mode, ex.h10, ex.h1, ex.m10, ex.m1);
         end
      end
   endtask

   // Monitor: an event is any change of mode/ld_*, any cnt_en, any load.
   logic [14:0] last_obs;
   bit          have_last = 1'b0;

   always @(negedge clk) begin : monitor
      ev_t         a;
      logic [14:0] obs;
      obs     = {mode, ld_min1, ld_min10, ld_hour1, ld_hour10};
      a.stamp = cyc;
      a.mode  = mode;
      a.m1    = ld_min1;
      a.m10   = ld_min10;
      a.h1    = ld_hour1;
      a.h10   = ld_hour10;
      if (!have_last || obs != last_obs) begin
         a.kind = K_CHG;
         check_ev(a, "state");
      end
      if (cnt_en) begin
         a.kind = K_CNT;
         check_ev(a, "cnt_en");
      end
      if (load) begin
         a.kind = K_LD;
         check_ev(a, "load");
      end
      last_obs  = obs;
      have_last = 1'b1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic set_time(input int h, input int m);
      cur_hour = h;
      cur_min  = m;
      hour10   = 2'(h / 10);
      hour1    = 4'(h % 10);
      min10    = 3'(m / 10);
      min1     = 4'(m % 10);
   endtask

   task automatic run_for(input int n);
      int c;
      c = cyc;
      for (int t = c + 1; t <= c + n; t++)
         if ((t - run_start) % int'(TD) == int'(TD) - 1)
            push(K_CNT, t);
      step(n);
   endtask

   task automatic mode_effect(input int c);
      case (e_mode)
         0: begin
            e_hour = cur_hour;
            e_min  = cur_min;
            e_mode = 1;
            push(K_CHG, c + 1);
         end
         1: begin
            e_mode = 2;
            push(K_CHG, c + 1);
         end
         2: begin
            e_mode = 3;
            push(K_CHG, c + 1);
            push(K_LD, c + 1);
            e_mode = 0;
            push(K_CHG, c + 2);
            run_start = c + 2;
         end
         default: ;
      endcase
   endtask

   task automatic inc_effect(input int stamp);
      if (e_mode == 1) begin
         e_hour = (e_hour + 1) % 24;
         push(K_CHG, stamp);
      end else if (e_mode == 2) begin
         e_min = (e_min + 1) % 60;
         push(K_CHG, stamp);
      end
   endtask

   task automatic press_mode();
      mode_effect(cyc);
      btn_mode = 1'b1;
      step(1);
      btn_mode = 1'b0;
      step(1);
   endtask

   task automatic press_inc();
      inc_effect(cyc + 1);
      btn_inc = 1'b1;
      step(1);
      btn_inc = 1'b0;
      step(1);
   endtask

   task automatic press_both();
      mode_effect(cyc);
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      step(1);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step(1);
   endtask

   // btn_inc high at n consecutive edges.
   task automatic hold_inc(input int n);
      int c;
      c = cyc;
      inc_effect(c + 1);
`ifdef CLOCK24_CTRL_AUTOREP_EN
      for (int t = c + 1 + int'(RD); t <= c + n; t += int'(RP))
         inc_effect(t);
`endif
      btn_inc = 1'b1;
      step(n);
      btn_inc = 1'b0;
      step(1);
   endtask

   // One-cycle reset mid-edit with btn_mode held high across it.
   task automatic reset_held();
      e_mode = 0;
      e_hour = 0;
      e_min  = 0;
      push(K_CHG, cyc + 1);
      reset    = 1'b0;
      btn_mode = 1'b1;
      step(1);
      reset     = 1'b1;
      run_start = cyc;
      run_for(4);
      btn_mode = 1'b0;
      run_for(3);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : stim
      set_time(13, 47);
      push(K_CHG, 1);                 // all-zero reset snapshot
      step(3);
      reset     = 1'b1;
      run_start = cyc;
      run_for(12);                    // cnt_en in post-reset cycles 4, 8, 12

      press_mode();                   // capture 13:47
      repeat (11) press_inc();        // 14..23, 00
      press_mode();
      repeat (13) press_inc();        // 48..59, 00
      press_mode();                   // load 00:00

      set_time(9, 30);
      run_for(5);
      press_mode();                   // capture 09:30
      press_both();                   // mode wins, hour stays 09
      press_mode();                   // load 09:30

      run_for(3);
      press_mode();                   // capture 09:30
      press_inc();                    // 10
      press_mode();
      press_mode();                   // load 10:30

      set_time(19, 5);
      run_for(2);
      press_mode();                   // capture 19:05
      press_inc();                    // 20
      press_mode();
      press_inc();                    // minutes 06
      reset_held();

      set_time(12, 0);
      run_for(4);
      press_mode();
      press_mode();                   // SET_MIN from 00
      hold_inc(21);                   // press plus 20 held cycles
      press_mode();                   // load
      run_for(8);
      step(2);

      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d required events never appeared, first kind=%0d cyc=%0d",
                  expq.size(), expq[0].kind, expq[0].stamp);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
